// File: rtl/flit_recv_pkg.sv
// rtl/flit_recv_pkg.sv - shared flit field layout, type codes and FSM states for flit_recv
package flit_recv_pkg;

    localparam int B      = 4;
    localparam int FW     = 59;
    localparam int FTW    = 3;
    localparam int SW     = 24;
    localparam int R_FLG  = 36;
    localparam int CFG_AW = 20;
    localparam int CFG_DW = 16;
    localparam int RT_W   = FW - FTW - R_FLG;

    localparam logic [FTW-1:0] T_SPIKE    = 3'b000;
    localparam logic [FTW-1:0] T_DATA     = 3'b001;
    localparam logic [FTW-1:0] T_DATA_END = 3'b010;
    localparam logic [FTW-1:0] T_WRITE    = 3'b110;
    localparam logic [FTW-1:0] T_READ     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_RESP = 2'd2
    } state_t;

    // Read responses travel back as DATA_END with an all-zero route field.
    function automatic logic [FW-1:0] make_resp(input logic [CFG_AW-1:0] addr,
                                                input logic [CFG_DW-1:0] data);
        return {T_DATA_END, {RT_W{1'b0}}, addr, data};
    endfunction

endpackage

// File: rtl/recv_fifo.sv
// rtl/recv_fifo.sv - first-word-fall-through flit buffer; a pop frees its slot before a same-cycle push
module recv_fifo #(
    parameter int AW = 4,
    parameter int W  = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_overflow
);

    logic [W-1:0] r_mem [2**AW];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_pop;
    logic         w_do_push;

    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign o_overflow = i_push && o_full && !w_do_pop;
    assign o_head     = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/flit_recv.sv
// rtl/flit_recv.sv - NoC receive stage: buffers flits, returns credits, dispatches by flit type
module flit_recv
    import flit_recv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flit_in_wr,
    input  logic [FW-1:0]     flit_in,
    output logic              credit_out,
    output logic              spk_in_valid,
    output logic [SW-1:0]     spk_in_neuid,
    input  logic              spk_in_ready,
    output logic              data_valid,
    output logic              data_last,
    output logic [R_FLG-1:0]  data_payload,
    input  logic              data_ready,
    output logic              cfg_we,
    output logic              cfg_re,
    output logic [CFG_AW-1:0] cfg_addr,
    output logic [CFG_DW-1:0] cfg_wdata,
    input  logic              cfg_rvalid,
    input  logic [CFG_DW-1:0] cfg_rdata,
    output logic              resp_we,
    output logic [FW-1:0]     resp_wdata,
    input  logic              resp_full,
    output logic              err_overflow,
    output logic              err_bad_type
);

    state_t              r_state;
    state_t              w_next;
    logic                r_credit;
    logic                r_err_ovf;
    logic                r_err_bad;
    logic [CFG_AW-1:0]   r_rd_addr;
    logic [CFG_DW-1:0]   r_rd_data;

    logic [FW-1:0]       w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_ovf;
    logic [FTW-1:0]      w_type;
    logic [R_FLG-1:0]    w_payload;
    logic                w_unused_route;

    logic                w_pop;
    logic                w_spk_valid;
    logic                w_data_valid;
    logic                w_cfg_we;
    logic                w_cfg_re;
    logic                w_resp_we;
    logic                w_bad;

    recv_fifo #(.AW(B), .W(FW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (flit_in_wr),
        .i_data     (flit_in),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_overflow (w_ovf)
    );

    assign w_type         = w_head[FW-1:FW-FTW];
    assign w_payload      = w_head[R_FLG-1:0];
    // The route field is consumed by the NoC; nothing downstream needs it.
    assign w_unused_route = ^{w_head[FW-FTW-1:R_FLG], w_full};

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_spk_valid  = 1'b0;
        w_data_valid = 1'b0;
        w_cfg_we     = 1'b0;
        w_cfg_re     = 1'b0;
        w_resp_we    = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    case (w_type)
                        T_SPIKE: begin
                            w_spk_valid = 1'b1;
                            w_pop       = spk_in_ready;
                        end
                        T_DATA, T_DATA_END: begin
                            w_data_valid = 1'b1;
                            w_pop        = data_ready;
                        end
                        T_WRITE: begin
                            w_cfg_we = 1'b1;
                            w_pop    = 1'b1;
                        end
                        // READ stays at the head until its response has been pushed.
                        T_READ: begin
                            w_cfg_re = 1'b1;
                            w_next   = S_RD_WAIT;
                        end
                        default: begin
                            w_pop = 1'b1;
                            w_bad = 1'b1;
                        end
                    endcase
                end
            end
            S_RD_WAIT: begin
                if (cfg_rvalid) w_next = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (!resp_full) begin
                    w_resp_we = 1'b1;
                    w_pop     = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_credit  <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_bad <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_next;
            r_credit  <= w_pop;
            r_err_ovf <= r_err_ovf | w_ovf;
            r_err_bad <= r_err_bad | w_bad;
            if (w_cfg_re) r_rd_addr <= w_payload[R_FLG-1:CFG_DW];
            if (r_state == S_RD_WAIT && cfg_rvalid) r_rd_data <= cfg_rdata;
        end
    end

    assign credit_out   = r_credit;
    assign spk_in_valid = w_spk_valid;
    assign spk_in_neuid = w_spk_valid ? w_payload[SW-1:0] : '0;
    assign data_valid   = w_data_valid;
    assign data_last    = w_data_valid && (w_type == T_DATA_END);
    assign data_payload = w_data_valid ? w_payload : '0;
    assign cfg_we       = w_cfg_we;
    assign cfg_re       = w_cfg_re;
    assign cfg_addr     = (w_cfg_we || w_cfg_re) ? w_payload[R_FLG-1:CFG_DW] : '0;
    assign cfg_wdata    = w_cfg_we ? w_payload[CFG_DW-1:0] : '0;
    assign resp_we      = w_resp_we;
    assign resp_wdata   = w_resp_we ? make_resp(r_rd_addr, r_rd_data) : '0;
    assign err_overflow = r_err_ovf;
    assign err_bad_type = r_err_bad;

endmodule

// File: tb/tb_flit_recv.sv
// tb/tb_flit_recv.sv - self-checking bench for flit_recv: directed cases, random traffic, event scoreboard
module tb_flit_recv;
    import flit_recv_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flit_in_wr = 1'b0;
    logic [FW-1:0]     flit_in = '0;
    logic              credit_out;
    logic              spk_in_valid;
    logic [SW-1:0]     spk_in_neuid;
    logic              spk_in_ready = 1'b0;
    logic              data_valid;
    logic              data_last;
    logic [R_FLG-1:0]  data_payload;
    logic              data_ready = 1'b0;
    logic              cfg_we;
    logic              cfg_re;
    logic [CFG_AW-1:0] cfg_addr;
    logic [CFG_DW-1:0] cfg_wdata;
    logic              cfg_rvalid = 1'b0;
    logic [CFG_DW-1:0] cfg_rdata = '0;
    logic              resp_we;
    logic [FW-1:0]     resp_wdata;
    logic              resp_full = 1'b0;
    logic              err_overflow;
    logic              err_bad_type;

    flit_recv dut (
        .clk(clk), .rst_n(rst_n), .flit_in_wr(flit_in_wr), .flit_in(flit_in),
        .credit_out(credit_out), .spk_in_valid(spk_in_valid), .spk_in_neuid(spk_in_neuid),
        .spk_in_ready(spk_in_ready), .data_valid(data_valid), .data_last(data_last),
        .data_payload(data_payload), .data_ready(data_ready), .cfg_we(cfg_we), .cfg_re(cfg_re),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
        .resp_we(resp_we), .resp_wdata(resp_wdata), .resp_full(resp_full),
        .err_overflow(err_overflow), .err_bad_type(err_bad_type)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    int acc_total = 0;
    int credit_cnt = 0;
    int rd_lat = 3;
    bit rand_mode = 0;

    logic any_out;
    assign any_out = |{credit_out, spk_in_valid, spk_in_neuid, data_valid, data_last, data_payload,
                       cfg_we, cfg_re, cfg_addr, cfg_wdata, resp_we, resp_wdata, err_overflow, err_bad_type};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_func(input logic [19:0] a);
        return a[15:0] ^ 16'hBEFF;
    endfunction

    function automatic logic [63:0] ev(input logic [2:0] k, input logic [60:0] v);
        return {k, v};
    endfunction

    function automatic logic [FW-1:0] mk(input logic [2:0] t, input logic [19:0] rt, input logic [35:0] pl);
        return {t, rt, pl};
    endfunction

    // Reference model: each accepted flit maps to the output events it must produce, in order.
    task automatic expect_flit(input logic [FW-1:0] f);
        logic [2:0]  t;
        logic [35:0] pl;
        t  = f[58:56];
        pl = f[35:0];
        case (t)
            3'b000:         exp_q.push_back(ev(3'd0, 61'(pl[23:0])));
            3'b001, 3'b010: exp_q.push_back(ev(3'd1, 61'({t == 3'b010, pl})));
            3'b110:         exp_q.push_back(ev(3'd2, 61'(pl)));
            3'b111: begin
                exp_q.push_back(ev(3'd3, 61'(pl[35:16])));
                exp_q.push_back(ev(3'd4, 61'({3'b010, 20'h0, pl[35:16], rd_func(pl[35:16])})));
            end
            default: ;
        endcase
    endtask

    task automatic send(input logic [FW-1:0] f, input bit accept);
        flit_in    = f;
        flit_in_wr = 1'b1;
        if (accept) begin
            expect_flit(f);
            acc_total++;
        end
        @(posedge clk); #1;
        flit_in_wr = 1'b0;
    endtask

    task automatic sb(input string tag, input logic [63:0] got);
        chk({tag, "_pending"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk(tag, got, exp_q.pop_front());
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || credit_cnt != acc_total) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_credits"}, 64'(credit_cnt), 64'(acc_total));
    endtask

    // Monitor: scoreboard of handshakes, stall stability, exclusivity, credit count.
    initial begin
        bit                pspk, pdat;
        logic [SW-1:0]     pneu;
        logic [R_FLG:0]    pdv;
        pspk = 0; pdat = 0; pneu = '0; pdv = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pspk = 0;
                pdat = 0;
            end else begin
                chk("onehot", 64'($countones({spk_in_valid, data_valid, cfg_we, cfg_re, resp_we}) <= 1), 64'd1);
                if (pspk) chk("spk_hold", 64'({spk_in_valid, spk_in_neuid}), 64'({1'b1, pneu}));
                if (pdat) chk("data_hold", 64'({data_valid, data_last, data_payload}), 64'({1'b1, pdv}));
                if (spk_in_valid && spk_in_ready) sb("spike", ev(3'd0, 61'(spk_in_neuid)));
                if (data_valid && data_ready) sb("data", ev(3'd1, 61'({data_last, data_payload})));
                if (cfg_we) sb("cfg_wr", ev(3'd2, 61'({cfg_addr, cfg_wdata})));
                if (cfg_re) sb("cfg_rd", ev(3'd3, 61'(cfg_addr)));
                if (resp_we) begin
                    chk("resp_full_low", 64'(resp_full), 64'd0);
                    sb("resp", ev(3'd4, 61'(resp_wdata)));
                end
                if (credit_out) credit_cnt++;
                pspk = spk_in_valid && !spk_in_ready;
                pneu = spk_in_neuid;
                pdat = data_valid && !data_ready;
                pdv  = {data_last, data_payload};
            end
        end
    end

    // Config read responder.
    initial begin
        logic [19:0] a;
        int          lat;
        forever begin
            @(negedge clk);
            if (rst_n && cfg_re) begin
                a   = cfg_addr;
                lat = rand_mode ? int'($urandom_range(1, 4)) : rd_lat;
                repeat (lat) @(posedge clk);
                #1;
                cfg_rvalid = 1'b1;
                cfg_rdata  = rd_func(a);
                @(posedge clk); #1;
                cfg_rvalid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_mode) begin
                spk_in_ready = ($urandom_range(0, 3) != 0);
                data_ready   = ($urandom_range(0, 3) != 0);
                resp_full    = ($urandom_range(0, 3) == 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          c0;
        logic [FW-1:0] exp_resp;
        logic [35:0] pl;
        logic [19:0] rt;
        int          r;
        int          n;

        // 1: reset state, then 15 spikes
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 64'(any_out), 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'(S_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        spk_in_ready = 1'b1;
        c0 = credit_cnt;
        for (int i = 1; i <= 15; i++) send(mk(3'b000, 20'h0, 36'(i)), 1);
        drain("t1");
        chk("t1_credit_cnt", 64'(credit_cnt - c0), 64'd15);
        chk("t1_no_ovf", 64'(err_overflow), 64'd0);
        chk("t1_no_bad", 64'(err_bad_type), 64'd0);

        // 2: overflow on the 17th flit
        spk_in_ready = 1'b0;
        c0 = credit_cnt;
        for (int i = 0; i < 16; i++) send(mk(3'b000, 20'h0, 36'(24'h100 + i)), 1);
        send(mk(3'b000, 20'h0, 36'h1FF), 0);
        chk("t2_ovf", 64'(err_overflow), 64'd1);
        chk("t2_no_credit", 64'(credit_cnt - c0), 64'd0);
        chk("t2_head", 64'({spk_in_valid, spk_in_neuid}), 64'({1'b1, 24'h100}));
        spk_in_ready = 1'b1;
        drain("t2");
        chk("t2_credit_cnt", 64'(credit_cnt - c0), 64'd16);

        // 3: config write
        send(mk(3'b110, 20'h0, {20'h00ABC, 16'h1234}), 1);
        chk("t3_we", 64'(cfg_we), 64'd1);
        chk("t3_addr", 64'(cfg_addr), 64'h00ABC);
        chk("t3_wdata", 64'(cfg_wdata), 64'h1234);
        @(posedge clk); #1;
        chk("t3_we_1cyc", 64'(cfg_we), 64'd0);
        chk("t3_credit", 64'(credit_cnt > 0 && credit_out), 64'd1);
        drain("t3");

        // 4: config read with response back-pressure
        resp_full = 1'b1;
        rd_lat    = 3;
        send(mk(3'b111, 20'h0, {20'h00010, 16'h0}), 1);
        chk("t4_re", 64'(cfg_re), 64'd1);
        chk("t4_addr", 64'(cfg_addr), 64'h00010);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("t4_full_hold", 64'(resp_we), 64'd0);
        end
        resp_full = 1'b0;
        #1;
        exp_resp = {3'b010, 20'h0, 20'h00010, 16'hBEEF};
        chk("t4_resp_we", 64'(resp_we), 64'd1);
        chk("t4_resp_data", 64'(resp_wdata), 64'(exp_resp));
        @(posedge clk); #1;
        chk("t4_resp_1cyc", 64'(resp_we), 64'd0);
        chk("t4_credit", 64'(credit_out), 64'd1);
        drain("t4");

        // 5: data stream with toggling ready
        data_ready = 1'b0;
        send(mk(3'b001, 20'h5, 36'hA_1111_2222), 1);
        send(mk(3'b001, 20'h5, 36'hB_3333_4444), 1);
        send(mk(3'b010, 20'h5, 36'hC_5555_6666), 1);
        for (int i = 0; i < 16; i++) begin
            data_ready = (i % 2 == 1);
            @(posedge clk); #1;
        end
        data_ready = 1'b1;
        drain("t5");

        // 6: bad type then spike
        chk("t6_bad_pre", 64'(err_bad_type), 64'd0);
        send(mk(3'b100, 20'h0, 36'h123), 1);
        send(mk(3'b000, 20'h0, 36'h0ABCDE), 1);
        drain("t6");
        chk("t6_bad", 64'(err_bad_type), 64'd1);

        // random traffic under an upstream credit budget of 2^B-1
        rand_mode = 1;
        for (int k = 0; k < 300; k++) begin
            n = 0;
            while (acc_total - credit_cnt >= 15 && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 2000) begin
                chk("rand_credit_wait", 64'(acc_total - credit_cnt), 64'd0);
                break;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            r  = int'($urandom_range(0, 9));
            pl = 36'({$urandom(), $urandom()});
            rt = 20'($urandom());
            case (r)
                0, 1, 2: send(mk(3'b000, rt, pl), 1);
                3, 4:    send(mk(3'b001, rt, pl), 1);
                5:       send(mk(3'b010, rt, pl), 1);
                6:       send(mk(3'b110, rt, pl), 1);
                7:       send(mk(3'b111, rt, pl), 1);
                8:       send(mk(3'b100, rt, pl), 1);
                default: send(mk(($urandom_range(0, 1) != 0) ? 3'b011 : 3'b101, rt, pl), 1);
            endcase
        end
        rand_mode = 0;
        @(posedge clk); #1;
        spk_in_ready = 1'b1;
        data_ready   = 1'b1;
        resp_full    = 1'b0;
        drain("rand");

        // reset in the middle of a stalled READ
        resp_full = 1'b1;
        rd_lat    = 2;
        send(mk(3'b111, 20'h0, {20'h00777, 16'h0}), 1);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("rr_stalled", 64'(resp_we), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rr_outs", 64'(any_out), 64'd0);
        chk("rr_state", 64'(dut.r_state), 64'(S_IDLE));
        @(posedge clk); #1;
        exp_q.delete();
        acc_total  = 0;
        credit_cnt = 0;
        resp_full  = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk); #1;
        send(mk(3'b000, 20'h0, 36'h00BEAD), 1);
        chk("rr_spk_after", 64'({spk_in_valid, spk_in_neuid}), 64'({1'b1, 24'h00BEAD}));
        drain("rr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
